// File: rtl/alu_serial_seq_if.sv
// Request/response bus between a client and the bit-serial ALU sequencer.
// Flag signals exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_serial_seq_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [1:0]   op_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout_o;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  modport master (
    output start, a_in, b_in, op_in,
`ifdef ALU_SEQ_FLAGS_EN
    input  zero, ovf,
`endif
    input  busy, done, result, cout_o
  );

  modport slave (
    input  start, a_in, b_in, op_in,
`ifdef ALU_SEQ_FLAGS_EN
    output zero, ovf,
`endif
    output busy, done, result, cout_o
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU cell LSB-first.
// Optional zero/ovf flags are built when ALU_SEQ_FLAGS_EN is defined.
module alu_serial_seq #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_serial_seq_if.slave   bus,
  output logic              o_alu_a,
  output logic              o_alu_b,
  output logic              o_alu_cin,
  output logic [1:0]        o_alu_op,
  input  logic              i_alu_s,
  input  logic              i_alu_cout
);
  localparam int KW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_last;
  logic         w_busy;
  logic         w_done;

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [1:0]    r_op;
  logic          r_carry;
  logic [KW-1:0] r_k;
  logic [N-1:0]  r_result;
  logic          r_cout;
  logic [N-1:0]  w_shifted;
`ifdef ALU_SEQ_FLAGS_EN
  logic          r_zero;
  logic          r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_k == KW'(N-1)) begin
          w_last = 1'b1;
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_shifted = {i_alu_s, r_result[N-1:1]};

  // Operands shift right so the cell always sees bit k on bit 0 of a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a_in;
      r_b     <= bus.b_in;
      r_op    <= bus.op_in;
      r_carry <= (bus.op_in == 2'b11);
      r_k     <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_result <= w_shifted;
      r_carry  <= i_alu_cout;
      r_k      <= r_k + KW'(1);
      if (w_last) begin
        r_cout <= i_alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
        r_zero <= (w_shifted == '0);
        r_ovf  <= r_op[1] & (r_carry ^ i_alu_cout);
`endif
      end
    end
  end

  assign o_alu_a    = r_a[0];
  assign o_alu_b    = r_b[0];
  assign o_alu_cin  = r_carry;
  assign o_alu_op   = r_op;

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.cout_o = r_cout;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.zero   = r_zero;
  assign bus.ovf    = r_ovf;
`endif
endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq with a behavioural alu1bit cell model.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_serial_seq;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] res;
    logic         cout;
    logic         chkCout;
    logic         zero;
    logic         ovf;
    int           startCyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       aluA, aluB, aluCin, aluS, aluCout, bEff;
  logic [1:0] aluOp;
  int         cyc;
  int         total;
  int         bad;
  exp_t       sb[$];

  alu_serial_seq_if #(.N(N)) bus ();

  alu_serial_seq #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_alu_a    (aluA),
    .o_alu_b    (aluB),
    .o_alu_cin  (aluCin),
    .o_alu_op   (aluOp),
    .i_alu_s    (aluS),
    .i_alu_cout (aluCout)
  );

  // Reference cell: b is inverted for op[0]=1, which makes op 11 a two's-complement subtract.
  always_comb begin
    bEff    = aluOp[0] ? ~aluB : aluB;
    aluCout = (aluA & bEff) | (aluA & aluCin) | (bEff & aluCin);
    case (aluOp)
      2'b00:   aluS = ~(aluA | aluB);
      2'b01:   aluS = aluA ^ aluB;
      default: aluS = aluA ^ bEff ^ aluCin;
    endcase
  end

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", 32'(bus.result), 32'(e.res));
        if (e.chkCout) checkOutput("cout_o", 32'(bus.cout_o), 32'(e.cout));
        checkOutput("latency", 32'(cyc - e.startCyc), 32'(N));
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("zero", 32'(bus.zero), 32'(e.zero));
        checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic issueOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                         input logic [N-1:0] expRes, input logic expCout, input logic chkCout,
                         input logic expZero, input logic expOvf);
    exp_t e;
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.op_in = op;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    e.res      = expRes;
    e.cout     = expCout;
    e.chkCout  = chkCout;
    e.zero     = expZero;
    e.ovf      = expOvf;
    e.startCyc = cyc;
    sb.push_back(e);
    checkOutput("busy after start", 32'(bus.busy), 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * N) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("done timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                               input logic [N-1:0] expRes, input logic expCout, input logic chkCout,
                               input logic expZero, input logic expOvf);
    issueOp(a, b, op, expRes, expCout, chkCout, expZero, expOvf);
    waitIdle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.op_in = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset result", 32'(bus.result), 32'd0);
    checkOutput("reset cout_o", 32'(bus.cout_o), 32'd0);
    checkOutput("reset alu pins", 32'({aluA, aluB, aluCin, aluOp}), 32'd0);
    rst = 1'b0;

    //            a      b      op     result cout chk zero ovf
    applyStimulus(8'h3C, 8'h05, 2'b10, 8'h41, 0, 1, 0, 0);
    applyStimulus(8'h07, 8'h05, 2'b11, 8'h02, 1, 1, 0, 0);
    applyStimulus(8'h05, 8'h07, 2'b11, 8'hFE, 0, 1, 0, 0);
    applyStimulus(8'hF0, 8'h0C, 2'b00, 8'h03, 0, 0, 0, 0);
    applyStimulus(8'hAA, 8'hFF, 2'b01, 8'h55, 0, 0, 0, 0);
    applyStimulus(8'hFF, 8'h01, 2'b10, 8'h00, 1, 1, 1, 0);
    applyStimulus(8'h7F, 8'h01, 2'b10, 8'h80, 0, 1, 0, 1);
    applyStimulus(8'h80, 8'h01, 2'b11, 8'h7F, 1, 1, 0, 1);
    applyStimulus(8'h5A, 8'h5A, 2'b01, 8'h00, 0, 0, 1, 0);

    // A start pulse mid-run must not disturb the running operation.
    issueOp(8'h12, 8'h34, 2'b10, 8'h46, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    bus.a_in  = 8'hFF;
    bus.b_in  = 8'hFF;
    bus.op_in = 2'b11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle();
    repeat (2 * N) @(negedge clk);
    checkOutput("held result", 32'(bus.result), 32'h46);

    // Reset during RUN aborts the operation with no done pulse.
    issueOp(8'h11, 8'h22, 2'b10, 8'h33, 0, 1, 0, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort result", 32'(bus.result), 32'd0);
    checkOutput("abort alu pins", 32'({aluA, aluB, aluCin, aluOp}), 32'd0);
    rst = 1'b0;
    repeat (2 * N) @(negedge clk);

    applyStimulus(8'h21, 8'h13, 2'b10, 8'h34, 0, 1, 0, 0);
    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
